// File: rtl/posix_to_calendar_if.sv
// Request/result bundle between the time-keeping counter and the calendar converter.
// Signal suffixes are from the converter's point of view.
interface posix_to_calendar_if #(
  parameter int unsigned TIME_W = 32,
  parameter int unsigned TZ_W   = 17,
  parameter int unsigned YEAR_W = 12
);
  logic [TIME_W-1:0] posix_i;
  logic [TZ_W-1:0]   tz_i;
  logic              posix_valid_i;
  logic              ready_o;
  logic              date_valid_o;
  logic              range_err_o;
  logic [YEAR_W-1:0] year_o;
  logic [3:0]        month_o;
  logic [4:0]        day_o;
  logic [2:0]        wday_o;
  logic [4:0]        hour_o;
  logic [5:0]        min_o;
  logic [5:0]        sec_o;
  logic [4:0]        month_days_o;
  logic [2:0]        month_first_wday_o;

  modport master (
    output posix_i, tz_i, posix_valid_i,
    input  ready_o, date_valid_o, range_err_o, year_o, month_o, day_o, wday_o,
           hour_o, min_o, sec_o, month_days_o, month_first_wday_o
  );

  modport slave (
    input  posix_i, tz_i, posix_valid_i,
    output ready_o, date_valid_o, range_err_o, year_o, month_o, day_o, wday_o,
           hour_o, min_o, sec_o, month_days_o, month_first_wday_o
  );
endinterface

// File: rtl/posix_to_calendar.sv
// Sequential POSIX-seconds to calendar converter: restoring divide by 86400, then
// year stepping, then month stepping. Holds the last good result between conversions.
module posix_to_calendar #(
  parameter int unsigned TIME_W     = 32,
  parameter int unsigned TZ_W       = 17,
  parameter int unsigned EPOCH_YEAR = 1970,
  parameter int unsigned EPOCH_WDAY = 4,
  parameter int unsigned MAX_YEAR   = 2999
) (
  input logic               clk_i,
  input logic               rst_i,
  posix_to_calendar_if.slave bus
);
  localparam int unsigned YEAR_W = $clog2(MAX_YEAR + 1);
  localparam int unsigned CNT_W  = $clog2(TIME_W);
  localparam int unsigned SUM_W  = TIME_W + 2;

  typedef enum logic [2:0] {StIdle, StDiv, StYear, StMonth, StDone} state_e;

  function automatic logic [2:0] mod7(input logic [5:0] x);
    logic [5:0] v;
    v = x;
    for (int i = 0; i < 5; i++) begin
      if (v >= 6'd7) v = v - 6'd7;
    end
    return v[2:0];
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  state_e            state_q, state_d;
  // Dividend, then quotient (days), then days remaining within the year/month.
  logic [TIME_W-1:0] t_q, t_d;
  logic [16:0]       sod_q, sod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        hr_q, hr_d;
  logic [5:0]        mn_q, mn_d, sc_q, sc_d;
  logic [YEAR_W-1:0] yr_q, yr_d;
  // Year mod 4/100/400 tracked incrementally so leap detection needs no divider.
  logic [1:0]        y4_q, y4_d;
  logic [6:0]        y100_q, y100_d;
  logic [8:0]        y400_q, y400_d;
  logic [3:0]        mon_q, mon_d;
  logic [2:0]        fwd_q, fwd_d;
  logic              err_q, err_d;

  logic [YEAR_W-1:0] out_year_q, out_year_d;
  logic [3:0]        out_month_q, out_month_d;
  logic [4:0]        out_day_q, out_day_d, out_hour_q, out_hour_d, out_mdays_q, out_mdays_d;
  logic [2:0]        out_wday_q, out_wday_d, out_mfwd_q, out_mfwd_d;
  logic [5:0]        out_min_q, out_min_d, out_sec_q, out_sec_d;
  logic              out_valid_q, out_valid_d, out_err_q, out_err_d;

  logic [SUM_W-1:0]  t_sum;
  logic [17:0]       div_r;
  logic              q_bit;
  logic [16:0]       sod_nx, rs;
  logic [4:0]        hr_c;
  logic [5:0]        mn_c, sc_c;
  logic              leap;
  logic [8:0]        ylen;
  logic [4:0]        mlen;

  assign t_sum  = {2'b00, bus.posix_i} + {{(SUM_W - TZ_W){bus.tz_i[TZ_W-1]}}, bus.tz_i};
  assign div_r  = {sod_q, t_q[TIME_W-1]};
  assign q_bit  = div_r >= 18'd86400;
  assign sod_nx = q_bit ? 17'(div_r - 18'd86400) : div_r[16:0];
  assign leap   = (y4_q == 2'd0) && ((y100_q != 7'd0) || (y400_q == 9'd0));
  assign ylen   = leap ? 9'd366 : 9'd365;
  assign mlen   = month_len(mon_q, leap);

  // Seconds-of-day split by constant compare/subtract chains.
  always_comb begin
    hr_c = '0;
    rs   = sod_nx;
    for (int h = 1; h < 24; h++) begin
      if (sod_nx >= 17'(h * 3600)) begin
        hr_c = 5'(h);
        rs   = sod_nx - 17'(h * 3600);
      end
    end
    mn_c = '0;
    sc_c = 6'(rs);
    for (int m = 1; m < 60; m++) begin
      if (rs >= 17'(m * 60)) begin
        mn_c = 6'(m);
        sc_c = 6'(rs - 17'(m * 60));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    sod_d       = sod_q;
    cnt_d       = cnt_q;
    hr_d        = hr_q;
    mn_d        = mn_q;
    sc_d        = sc_q;
    yr_d        = yr_q;
    y4_d        = y4_q;
    y100_d      = y100_q;
    y400_d      = y400_q;
    mon_d       = mon_q;
    fwd_d       = fwd_q;
    err_d       = err_q;
    out_year_d  = out_year_q;
    out_month_d = out_month_q;
    out_day_d   = out_day_q;
    out_wday_d  = out_wday_q;
    out_hour_d  = out_hour_q;
    out_min_d   = out_min_q;
    out_sec_d   = out_sec_q;
    out_mdays_d = out_mdays_q;
    out_mfwd_d  = out_mfwd_q;
    out_valid_d = 1'b0;
    out_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.posix_valid_i) begin
          err_d   = t_sum[SUM_W-1] | t_sum[SUM_W-2];
          t_d     = t_sum[TIME_W-1:0];
          sod_d   = '0;
          cnt_d   = '0;
          yr_d    = YEAR_W'(EPOCH_YEAR);
          y4_d    = 2'(EPOCH_YEAR % 4);
          y100_d  = 7'(EPOCH_YEAR % 100);
          y400_d  = 9'(EPOCH_YEAR % 400);
          mon_d   = 4'd1;
          fwd_d   = 3'(EPOCH_WDAY);
          state_d = (t_sum[SUM_W-1] | t_sum[SUM_W-2]) ? StDone : StDiv;
        end
      end
      StDiv: begin
        t_d   = {t_q[TIME_W-2:0], q_bit};
        sod_d = sod_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TIME_W - 1)) begin
          hr_d    = hr_c;
          mn_d    = mn_c;
          sc_d    = sc_c;
          state_d = StYear;
        end
      end
      StYear: begin
        if (t_q >= TIME_W'(ylen)) begin
          if (yr_q >= YEAR_W'(MAX_YEAR)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            t_d    = t_q - TIME_W'(ylen);
            yr_d   = yr_q + YEAR_W'(1);
            y4_d   = y4_q + 2'd1;
            y100_d = (y100_q == 7'd99) ? 7'd0 : y100_q + 7'd1;
            y400_d = (y400_q == 9'd399) ? 9'd0 : y400_q + 9'd1;
            fwd_d  = mod7({3'b000, fwd_q} + (leap ? 6'd2 : 6'd1));
          end
        end else begin
          state_d = StMonth;
        end
      end
      StMonth: begin
        if (t_q >= TIME_W'(mlen)) begin
          t_d   = t_q - TIME_W'(mlen);
          mon_d = mon_q + 4'd1;
          fwd_d = mod7({3'b000, fwd_q} + {1'b0, mlen});
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid_d = 1'b1;
        out_err_d   = err_q;
        if (!err_q) begin
          out_year_d  = yr_q;
          out_month_d = mon_q;
          out_day_d   = t_q[4:0] + 5'd1;
          out_wday_d  = mod7({3'b000, fwd_q} + {1'b0, t_q[4:0]});
          out_hour_d  = hr_q;
          out_min_d   = mn_q;
          out_sec_d   = sc_q;
          out_mdays_d = mlen;
          out_mfwd_d  = fwd_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      t_q         <= '0;
      sod_q       <= '0;
      cnt_q       <= '0;
      hr_q        <= '0;
      mn_q        <= '0;
      sc_q        <= '0;
      yr_q        <= YEAR_W'(EPOCH_YEAR);
      y4_q        <= 2'(EPOCH_YEAR % 4);
      y100_q      <= 7'(EPOCH_YEAR % 100);
      y400_q      <= 9'(EPOCH_YEAR % 400);
      mon_q       <= 4'd1;
      fwd_q       <= 3'(EPOCH_WDAY);
      err_q       <= 1'b0;
      out_year_q  <= YEAR_W'(EPOCH_YEAR);
      out_month_q <= 4'd1;
      out_day_q   <= 5'd1;
      out_wday_q  <= 3'(EPOCH_WDAY);
      out_hour_q  <= '0;
      out_min_q   <= '0;
      out_sec_q   <= '0;
      out_mdays_q <= 5'd31;
      out_mfwd_q  <= 3'(EPOCH_WDAY);
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      sod_q       <= sod_d;
      cnt_q       <= cnt_d;
      hr_q        <= hr_d;
      mn_q        <= mn_d;
      sc_q        <= sc_d;
      yr_q        <= yr_d;
      y4_q        <= y4_d;
      y100_q      <= y100_d;
      y400_q      <= y400_d;
      mon_q       <= mon_d;
      fwd_q       <= fwd_d;
      err_q       <= err_d;
      out_year_q  <= out_year_d;
      out_month_q <= out_month_d;
      out_day_q   <= out_day_d;
      out_wday_q  <= out_wday_d;
      out_hour_q  <= out_hour_d;
      out_min_q   <= out_min_d;
      out_sec_q   <= out_sec_d;
      out_mdays_q <= out_mdays_d;
      out_mfwd_q  <= out_mfwd_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.ready_o            = (state_q == StIdle);
  assign bus.date_valid_o       = out_valid_q;
  assign bus.range_err_o        = out_err_q;
  assign bus.year_o             = out_year_q;
  assign bus.month_o            = out_month_q;
  assign bus.day_o              = out_day_q;
  assign bus.wday_o             = out_wday_q;
  assign bus.hour_o             = out_hour_q;
  assign bus.min_o              = out_min_q;
  assign bus.sec_o              = out_sec_q;
  assign bus.month_days_o       = out_mdays_q;
  assign bus.month_first_wday_o = out_mfwd_q;
endmodule
